// File: rtl/shift_sin_pload_if.sv
// Consumer-side and serial-pin bundle for the TIPI receive shifter.
// slave  : the shifter itself (samples pins, drives the parallel result)
// master : whatever drives the pins and consumes the parallel byte
interface shift_sin_pload_if #(
   parameter int DATA_WIDTH = 8
);
   logic                  sclk;
   logic                  select;
   logic                  sin;
   logic                  ack;
   logic [DATA_WIDTH-1:0] data_out;
   logic                  valid;
   logic                  parity_err;
   logic                  overrun;
   logic                  frame_abort;

   modport slave (
      input  sclk, select, sin, ack,
      output data_out, valid, parity_err, overrun, frame_abort
   );

   modport master (
      output sclk, select, sin, ack,
      input  data_out, valid, parity_err, overrun, frame_abort
   );
endinterface

// File: rtl/shift_sin_pload.sv
// TIPI receive shifter: deserialises MSB-first frames of DATA_WIDTH data
// bits plus one even-XOR parity bit, clocked by an external sclk that is
// oversampled in the clk domain. The completed byte is handed to the
// register file through a valid/ack handshake.
module shift_sin_pload #(
   parameter int DATA_WIDTH  = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             reset_n,
   shift_sin_pload_if.slave bus
);

   localparam int            CW   = $clog2(DATA_WIDTH + 1);
   localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH);

   // sclk, sin and select share one depth so a bit and its clock edge
   // emerge from the synchronisers on the same cycle.
   logic [SYNC_STAGES-1:0] sclk_sync_q;
   logic [SYNC_STAGES-1:0] sin_sync_q;
   logic [SYNC_STAGES-1:0] sel_sync_q;
   logic                   sclk_prev_q;

   logic [DATA_WIDTH-1:0]  shift_q,  shift_d;
   logic [CW-1:0]          cnt_q,    cnt_d;
   logic [DATA_WIDTH-1:0]  data_q,   data_d;
   logic                   valid_q,  valid_d;
   logic                   perr_q,   perr_d;
   logic                   ovr_q,    ovr_d;
   logic                   abort_q,  abort_d;
   // Completion marker: valid follows one clk after data_out is loaded.
   logic                   done_q,   done_d;

   logic sclk_s;
   logic sin_s;
   logic sel_s;
   logic shift_ev;
   logic complete;

   assign sclk_s   = sclk_sync_q[SYNC_STAGES-1];
   assign sin_s    = sin_sync_q[SYNC_STAGES-1];
   assign sel_s    = sel_sync_q[SYNC_STAGES-1];
   assign shift_ev = sclk_s & ~sclk_prev_q & sel_s;
   assign complete = shift_ev && (cnt_q == LAST);

   // Bring the three asynchronous pins into the clk domain.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sclk_sync_q <= '0;
         sin_sync_q  <= '0;
         sel_sync_q  <= '0;
         sclk_prev_q <= 1'b0;
      end else begin
         sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], bus.sclk};
         sin_sync_q  <= {sin_sync_q[SYNC_STAGES-2:0],  bus.sin};
         sel_sync_q  <= {sel_sync_q[SYNC_STAGES-2:0],  bus.select};
         sclk_prev_q <= sclk_s;
      end
   end

   // Next-state for the shifter, frame counter and handshake flags.
   always_comb begin
      shift_d = shift_q;
      cnt_d   = cnt_q;
      data_d  = data_q;
      valid_d = valid_q;
      perr_d  = perr_q;
      ovr_d   = ovr_q;
      abort_d = 1'b0;
      done_d  = 1'b0;

      if (!sel_s) begin
         // Dropping select mid-frame throws the partial bits away.
         if (cnt_q != '0) begin
            abort_d = 1'b1;
            shift_d = '0;
         end
         cnt_d = '0;
      end else if (shift_ev) begin
         if (cnt_q == LAST) begin
            data_d = shift_q;
            perr_d = (^shift_q) != sin_s;
            cnt_d  = '0;
            done_d = 1'b1;
            if (valid_q && !bus.ack) begin
               ovr_d = 1'b1;
            end
         end else begin
            shift_d = {shift_q[DATA_WIDTH-2:0], sin_s};
            cnt_d   = cnt_q + CW'(1);
         end
      end

      // A completing frame beats a coincident ack; ack then has no effect.
      if (done_q) begin
         valid_d = 1'b1;
      end else if (bus.ack && valid_q && !complete) begin
         valid_d = 1'b0;
         ovr_d   = 1'b0;
      end
   end

   // Register the shifter state and all outputs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         shift_q <= '0;
         cnt_q   <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         perr_q  <= 1'b0;
         ovr_q   <= 1'b0;
         abort_q <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         shift_q <= shift_d;
         cnt_q   <= cnt_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         perr_q  <= perr_d;
         ovr_q   <= ovr_d;
         abort_q <= abort_d;
         done_q  <= done_d;
      end
   end

   assign bus.data_out    = data_q;
   assign bus.valid       = valid_q;
   assign bus.parity_err  = perr_q;
   assign bus.overrun     = ovr_q;
   assign bus.frame_abort = abort_q;

endmodule

// File: tb/tb_shift_sin_pload.sv
// Directed plus randomised frames against a frame-level reference model
// (data byte, parity bit, ack timing) of the TIPI receive shifter.
module tb_shift_sin_pload;

   localparam int DW = 8;

   logic clk;
   logic reset_n;

   shift_sin_pload_if #(.DATA_WIDTH(DW)) bus ();

   shift_sin_pload #(.DATA_WIDTH(DW), .SYNC_STAGES(2)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int vecs;
   int miscompares;

   // Reference model: what the consumer should see.
   logic [DW-1:0] m_data;
   logic          m_valid;
   logic          m_perr;
   logic          m_ovr;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vecs++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_outputs(input string tag);
      chk({tag, ".data"},  32'(bus.data_out),    32'(m_data));
      chk({tag, ".valid"}, 32'(bus.valid),       32'(m_valid));
      chk({tag, ".perr"},  32'(bus.parity_err),  32'(m_perr));
      chk({tag, ".ovr"},   32'(bus.overrun),     32'(m_ovr));
      chk({tag, ".abort"}, 32'(bus.frame_abort), 32'(0));
   endtask

   task automatic model_reset();
      m_data  = '0;
      m_valid = 1'b0;
      m_perr  = 1'b0;
      m_ovr   = 1'b0;
   endtask

   task automatic model_complete(input logic [DW-1:0] d, input logic p, input bit ack_hit);
      if (m_valid && !ack_hit) m_ovr = 1'b1;
      m_data  = d;
      m_perr  = (^d) != p;
      m_valid = 1'b1;
   endtask

   // One sclk period; optional ack lands in the completion cycle
   // (two sync stages plus the edge-detect register after the rise).
   task automatic send_bit(input logic b, input bit ack_hit);
      int lo;
      int hi;
      lo = $urandom_range(3, 6);
      hi = $urandom_range(4, 7);
      bus.sin = b;
      repeat (lo) @(negedge clk);
      bus.sclk = 1'b1;
      if (ack_hit) begin
         repeat (2) @(negedge clk);
         bus.ack = 1'b1;
         @(negedge clk);
         bus.ack = 1'b0;
         repeat (hi - 3) @(negedge clk);
      end else begin
         repeat (hi) @(negedge clk);
      end
      bus.sclk = 1'b0;
   endtask

   task automatic send_frame(input logic [DW-1:0] d, input logic p, input bit ack_hit);
      bus.select = 1'b1;
      for (int i = DW - 1; i >= 0; i--) send_bit(d[i], 1'b0);
      send_bit(p, ack_hit);
      model_complete(d, p, ack_hit);
      repeat (4) @(negedge clk);
   endtask

   task automatic do_ack();
      @(negedge clk);
      bus.ack = 1'b1;
      @(negedge clk);
      bus.ack = 1'b0;
      if (m_valid) begin
         m_valid = 1'b0;
         m_ovr   = 1'b0;
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic count_abort(input int cycles, output int pulses);
      pulses = 0;
      repeat (cycles) begin
         @(negedge clk);
         if (bus.frame_abort) pulses++;
      end
   endtask

   logic [DW-1:0] rd;
   logic          rp;
   int            pulses;
   int            nb;

   initial begin
      vecs        = 0;
      miscompares = 0;
      model_reset();
      bus.sclk   = 1'b0;
      bus.select = 1'b0;
      bus.sin    = 1'b0;
      bus.ack    = 1'b0;
      reset_n    = 1'b0;

      // Reset held while the pins wiggle
      repeat (6) begin
         @(negedge clk);
         bus.sclk   = ~bus.sclk;
         bus.sin    = ~bus.sin;
         bus.select = ~bus.select;
      end
      bus.sclk = 1'b0; bus.sin = 1'b0; bus.select = 1'b0;
      repeat (4) @(negedge clk);
      chk_outputs("reset");
      reset_n = 1'b1;
      repeat (5) @(negedge clk);
      chk_outputs("post_reset");

      // Good frame 0xA5 with latency probe on the parity bit
      bus.select = 1'b1;
      for (int i = DW - 1; i >= 0; i--) begin
         rd = 8'hA5;
         send_bit(rd[i], 1'b0);
      end
      bus.sin = 1'b0;
      repeat (4) @(negedge clk);
      bus.sclk = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("lat2.data",  32'(bus.data_out), 32'h00);
      chk("lat2.valid", 32'(bus.valid),    32'(0));
      @(posedge clk);
      #1;
      chk("lat3.data",  32'(bus.data_out), 32'hA5);
      chk("lat3.valid", 32'(bus.valid),    32'(0));
      @(posedge clk);
      #1;
      chk("lat4.valid", 32'(bus.valid),    32'(1));
      repeat (3) @(negedge clk);
      bus.sclk = 1'b0;
      model_complete(8'hA5, 1'b0, 1'b0);
      repeat (4) @(negedge clk);
      chk_outputs("good_a5");
      do_ack();
      chk_outputs("ack_a5");

      // Bad parity
      send_frame(8'h01, 1'b0, 1'b0);
      chk_outputs("bad_par");
      do_ack();
      chk_outputs("ack_bad_par");

      // Overrun
      send_frame(8'h3C, 1'b0, 1'b0);
      chk_outputs("ovr_first");
      send_frame(8'hC3, 1'b0, 1'b0);
      chk_outputs("ovr_second");
      do_ack();
      chk_outputs("ovr_ack");

      // Abort after 4 bits, then a clean frame
      bus.select = 1'b1;
      for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0);
      @(negedge clk);
      bus.select = 1'b0;
      count_abort(10, pulses);
      chk("abort4.pulses", 32'(pulses), 32'(1));
      chk_outputs("abort4");
      send_frame(8'h7E, 1'b0, 1'b0);
      chk_outputs("after_abort");
      do_ack();

      // Ack collides with completion
      send_frame(8'h11, 1'b0, 1'b0);
      send_frame(8'h22, 1'b0, 1'b1);
      chk_outputs("ack_collide");
      do_ack();
      chk_outputs("ack_collide_clr");

      // Select drop with no bits pending: no pulse
      @(negedge clk);
      bus.select = 1'b0;
      count_abort(8, pulses);
      chk("idle_drop.pulses", 32'(pulses), 32'(0));

      // Randomised frames, acks, drops and aborts
      for (int f = 0; f < 24; f++) begin
         rd = 8'($urandom);
         rp = (^rd) ^ ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 3) == 0) begin
            nb = $urandom_range(1, DW);
            bus.select = 1'b1;
            for (int i = 0; i < nb; i++) send_bit(1'($urandom), 1'b0);
            @(negedge clk);
            bus.select = 1'b0;
            count_abort(8, pulses);
            chk("rnd_abort.pulses", 32'(pulses), 32'(1));
         end
         send_frame(rd, rp, ($urandom_range(0, 4) == 0));
         chk_outputs("rnd_frame");
         if ($urandom_range(0, 2) != 0) begin
            do_ack();
            chk_outputs("rnd_ack");
         end
         if ($urandom_range(0, 2) == 0) begin
            @(negedge clk);
            bus.select = 1'b0;
            count_abort(6, pulses);
            chk("rnd_drop.pulses", 32'(pulses), 32'(0));
         end
      end

      // Reset mid-frame: partial bits lost, no abort pulse
      bus.select = 1'b1;
      for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b0);
      @(negedge clk);
      reset_n = 1'b0;
      model_reset();
      #1;
      chk_outputs("mid_reset");
      bus.select = 1'b0;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      count_abort(6, pulses);
      chk("mid_reset.pulses", 32'(pulses), 32'(0));
      send_frame(8'h5A, 1'b0, 1'b0);
      chk_outputs("after_reset_frame");

      $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
      $finish;
   end

endmodule

// File: doc/shift_sin_pload.md
Name: shift_sin_pload

Overview:
- Receive-side counterpart of the TIPI parallel-load/serial-out shifter.
- Deserialises frames of DATA_WIDTH data bits, MSB first, followed by one parity bit equal to XOR of the data bits.
- Samples an external serial clock and line into the system clock domain, then presents a parallel byte with a valid/ack handshake, a parity-error flag and an overrun flag.
- Sits between the TIPI serial pins (Pi side) and the TIPI register file.

Parameters:
- DATA_WIDTH, 8, number of data bits per frame; the frame is DATA_WIDTH+1 bits.
- SYNC_STAGES, 2, synchroniser depth for sclk, sin and select (minimum 2).

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- sclk  input  1  external serial clock, asynchronous to clk; data is captured on its rising edge.
- select  input  1  external frame enable, asynchronous; high = frame in progress.
- sin  input  1  serial data in, MSB first, parity bit last.
- ack  input  1  consumer acknowledges data_out; clears valid.
- data_out  output  DATA_WIDTH  last completed frame's data bits.
- valid  output  1  data_out holds an unconsumed frame.
- parity_err  output  1  last completed frame failed the parity check.
- overrun  output  1  sticky; a frame completed while valid was still set.
- frame_abort  output  1  one-clk pulse when select drops mid-frame.

Behaviour:
- Reset (reset_n low, asynchronous): all synchroniser flops, shift register, bit counter, data_out, valid, parity_err, overrun and frame_abort go to 0.
- Synchronisers: sclk, sin and select each pass through SYNC_STAGES flops reset to 0. sin and select use the same depth as sclk so that all three stay aligned.
- Shift event: a cycle where synchronised sclk is 1, its previous registered value is 0, and synchronised select is 1.
- Latency: pin edge to shift event is SYNC_STAGES+1 clk cycles.
- Timing requirement: sclk high and low phases must each last at least SYNC_STAGES+1 clk periods. Faster edges are out of spec and need not be captured.
- Bit counter: counts 0..DATA_WIDTH.
- On a shift event with count < DATA_WIDTH: shift register becomes its previous contents shifted left by one with synchronised sin in bit 0; count increments.
- On a shift event with count == DATA_WIDTH (the parity bit), the frame completes:
  - data_out is loaded from the shift register.
  - parity_err is set to 1 if XOR of the shift register bits differs from synchronised sin, else 0.
  - count returns to 0.
  - valid goes to 1 on the next clk edge.
- Overrun: if valid is already 1 at completion and ack is not asserted that cycle, set overrun to 1. The new frame overwrites data_out and parity_err.
- ack with valid set and no completion in the same cycle: valid goes to 0 and overrun goes to 0. parity_err is held until the next completion.
- Simultaneous ack and completion: completion wins. valid stays 1, new data is loaded, overrun is not set.
- ack while valid is 0: ignored.
- Abort: synchronised select low with count != 0 resets count to 0, discards the partial bits and pulses frame_abort for exactly one cycle. If count == 0, select low produces no pulse.
- While select is low: shift events are suppressed and count holds 0.
- Reset mid-frame: partial frame is lost and no abort pulse is generated.

Test Plan:
- Reset: hold reset_n low and toggle sclk/sin -> all outputs 0; release reset -> outputs stay 0 until a full frame arrives.
- Good frame: select high, shift 1,0,1,0,0,1,0,1 then parity 0 (XOR of 0xA5 is 0) -> valid rises SYNC_STAGES+1 cycles plus one after the 9th sclk edge; data_out = 0xA5; parity_err = 0. Pulse ack -> valid 0.
- Bad parity: frame 0x01 with parity bit 0 -> data_out = 0x01, parity_err = 1, valid = 1.
- Overrun: send 0x3C (parity 0) with no ack, then 0xC3 (parity 0) -> data_out = 0xC3, overrun = 1. Ack -> valid 0, overrun 0.
- Abort: shift 4 bits, drop select -> frame_abort pulses once, no valid. Raise select and send 0x7E (parity 0) -> data_out = 0x7E, no stale bits.
- Ack collision: send 0x11 and leave it unacked; during the next frame (0x22, parity 0), assert ack in the exact completion cycle -> valid stays 1, data_out = 0x22, overrun = 0.
